// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling queue, 1 write / up to 2 reads per cycle
//
// Purpose: circular buffer between the single-issue fetch stage and the
// dual-slot decode stage. Presents the two oldest entries in program order
// and discards all contents on a redirect.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flush                        redirect from execute; empties the queue
//   ValidF, InstrF, PCF, PCPlus4F  fetch-side entry, accepted when not full
//   StallF                       queue full (fetch enable = ~StallF)
//   ValidD0/1, InstrD0/1, PCD0/1, PCPlus4D0/1  oldest / next-oldest slots
//   PopD                         entries consumed by decode this cycle
//   Count                        current occupancy
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ValidF,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  output logic                       StallF,
  output logic                       ValidD0,
  output logic                       ValidD1,
  output logic [WIDTH-1:0]           InstrD0,
  output logic [WIDTH-1:0]           PCD0,
  output logic [WIDTH-1:0]           PCPlus4D0,
  output logic [WIDTH-1:0]           InstrD1,
  output logic [WIDTH-1:0]           PCD1,
  output logic [WIDTH-1:0]           PCPlus4D1,
  input  logic [1:0]                 PopD,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_instr [DEPTH];
  logic [WIDTH-1:0] r_pc    [DEPTH];
  logic [WIDTH-1:0] r_pc4   [DEPTH];

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_accept;
  logic [CW-1:0] w_pop;
  logic [PW-1:0] w_rd_ptr1;

  // Full is taken from the registered count only: a pop in the same cycle
  // does not free space for that cycle's write.
  assign w_full    = (r_count == FULL_CNT);
  assign w_accept  = ValidF && !w_full && !flush;
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);

  // Decode may ask for more than is held; silently clamp to occupancy.
  always_comb begin
    w_pop = CW'(PopD);
    if (CW'(PopD) > r_count) begin
      w_pop = r_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + w_pop[PW-1:0];
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_accept) - w_pop;
    end
  end

  // Payload storage needs no reset; validity is carried by r_count alone.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_instr[r_wr_ptr] <= InstrF;
      r_pc[r_wr_ptr]    <= PCF;
      r_pc4[r_wr_ptr]   <= PCPlus4F;
    end
  end

  always_comb begin
    ValidD0   = (r_count >= CW'(1));
    ValidD1   = (r_count >= CW'(2));
    InstrD0   = '0;
    PCD0      = '0;
    PCPlus4D0 = '0;
    InstrD1   = '0;
    PCD1      = '0;
    PCPlus4D1 = '0;
    if (ValidD0) begin
      InstrD0   = r_instr[r_rd_ptr];
      PCD0      = r_pc[r_rd_ptr];
      PCPlus4D0 = r_pc4[r_rd_ptr];
    end
    if (ValidD1) begin
      InstrD1   = r_instr[w_rd_ptr1];
      PCD1      = r_pc[w_rd_ptr1];
      PCPlus4D1 = r_pc4[w_rd_ptr1];
    end
  end

  assign StallF = w_full;
  assign Count  = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ValidF = 1'b0;
  logic [31:0] InstrF = '0;
  logic [31:0] PCF = '0;
  logic [31:0] PCPlus4F = '0;
  logic        StallF;
  logic        ValidD0, ValidD1;
  logic [31:0] InstrD0, PCD0, PCPlus4D0;
  logic [31:0] InstrD1, PCD1, PCPlus4D1;
  logic [1:0]  PopD = '0;
  logic [3:0]  Count;

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .StallF(StallF),
    .ValidD0(ValidD0), .ValidD1(ValidD1),
    .InstrD0(InstrD0), .PCD0(PCD0), .PCPlus4D0(PCPlus4D0),
    .InstrD1(InstrD1), .PCD1(PCD1), .PCPlus4D1(PCPlus4D1),
    .PopD(PopD), .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0] next_pc = '0;
  logic        acc;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the scoreboard contents.
  task automatic check_all(input string tag);
    ent_t e0, e1;
    e0 = '0;
    e1 = '0;
    if (sb.size() >= 1) e0 = sb[0];
    if (sb.size() >= 2) e1 = sb[1];
    check({tag, ".Count"},   32'(Count),   32'(sb.size()));
    check({tag, ".StallF"},  32'(StallF),  32'(sb.size() == DEPTH));
    check({tag, ".ValidD0"}, 32'(ValidD0), 32'(sb.size() >= 1));
    check({tag, ".ValidD1"}, 32'(ValidD1), 32'(sb.size() >= 2));
    check({tag, ".InstrD0"}, InstrD0, e0.instr);
    check({tag, ".PCD0"},    PCD0,    e0.pc);
    check({tag, ".PC4D0"},   PCPlus4D0, e0.pc4);
    check({tag, ".InstrD1"}, InstrD1, e1.instr);
    check({tag, ".PCD1"},    PCD1,    e1.pc);
    check({tag, ".PC4D1"},   PCPlus4D1, e1.pc4);
  endtask

  // One clock cycle: drive on negedge, update model at posedge, check 1 after.
  task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] pd,
                      input logic fl, output logic accepted);
    int npop;
    ent_t e;
    @(negedge clk);
    ValidF   = v;
    PCF      = pc;
    InstrF   = instr_of(pc);
    PCPlus4F = pc + 32'd4;
    PopD     = pd;
    flush    = fl;
    @(posedge clk);
    accepted = v && !fl && (sb.size() < DEPTH);
    if (fl) begin
      sb.delete();
    end else begin
      npop = (int'(pd) < sb.size()) ? int'(pd) : sb.size();
      for (int k = 0; k < npop; k++) void'(sb.pop_front());
      if (accepted) begin
        e.instr = instr_of(pc);
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        sb.push_back(e);
      end
    end
    #1;
    check_all("step");
    @(negedge clk);
    ValidF = 1'b0;
    PopD   = 2'd0;
    flush  = 1'b0;
  endtask

  // Fetch-like write: PC only advances when the queue took the instruction.
  task automatic fetch(input logic [1:0] pd);
    logic a;
    step(1'b1, next_pc, pd, 1'b0, a);
    if (a) next_pc = next_pc + 32'd4;
  endtask

  initial begin
    // Reset held, outputs must be cleared.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single fill of three.
    for (int i = 0; i < 3; i++) fetch(2'd0);
    check("fill3.Count", 32'(Count), 32'd3);
    check("fill3.PCD0", PCD0, 32'h0);
    check("fill3.PCD1", PCD1, 32'h4);
    check("fill3.StallF", 32'(StallF), 32'd0);

    // Six more writes: reaches full, the ninth is rejected.
    for (int i = 0; i < 6; i++) fetch(2'd0);
    check("full.Count", 32'(Count), 32'd8);
    check("full.StallF", 32'(StallF), 32'd1);
    check("full.nextpc", next_pc, 32'h20);

    // Pop with a write while full: write still rejected.
    step(1'b1, next_pc, 2'd1, 1'b0, acc);
    check("fullpop.acc", 32'(acc), 32'd0);
    check("fullpop.Count", 32'(Count), 32'd7);

    // Refill to 8 then dual pop with one write per cycle across the wrap.
    fetch(2'd0);
    check("refill.Count", 32'(Count), 32'd8);
    for (int i = 0; i < 6; i++) fetch(2'd2);

    // Drain down to a single entry.
    while (sb.size() > 1) begin
      step(1'b0, 32'h0, (sb.size() == 2) ? 2'd1 : 2'd2, 1'b0, acc);
    end
    // Over-pop clamp.
    step(1'b0, 32'h0, 2'd2, 1'b0, acc);
    check("clamp.Count", 32'(Count), 32'd0);
    check("clamp.ValidD0", 32'(ValidD0), 32'd0);
    // Order after clamp proves the read pointer moved by exactly one.
    fetch(2'd0);
    fetch(2'd0);
    fetch(2'd1);

    // Flush priority over write and pop.
    while (sb.size() < 5) fetch(2'd0);
    check("preflush.Count", 32'(Count), 32'd5);
    step(1'b1, 32'hDEAD_0000, 2'd2, 1'b1, acc);
    check("flush.Count", 32'(Count), 32'd0);
    check("flush.ValidD0", 32'(ValidD0), 32'd0);
    check("flush.StallF", 32'(StallF), 32'd0);
    next_pc = 32'h0000_1000;
    fetch(2'd0);
    check("postflush.PCD0", PCD0, 32'h0000_1000);

    // Asynchronous reset mid-stream, between edges.
    while (sb.size() < 4) fetch(2'd0);
    check("prerst.Count", 32'(Count), 32'd4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_all("asyncrst");
    @(negedge clk);
    rst = 1'b0;
    next_pc = 32'h0000_2000;
    fetch(2'd0);
    fetch(2'd0);
    check("postrst.PCD0", PCD0, 32'h0000_2000);
    check("postrst.PCD1", PCD1, 32'h0000_2004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
